dzmcu: RTL and testbench

- Memory control unit directly downstream of the CPU core's MCU bus (address, write data, write enable, read request).
- Decodes the 16-bit GB address space into boot ROM, cartridge, VRAM, WRAM (+echo), OAM, IO, HRAM and IE, and returns read data with a fixed 1-cycle latency.
- Owns the boot ROM overlay latch (FF50) and the OAM DMA engine (FF46), which arbitrates the bus against the CPU.

---
 rtl/dzmcu_pkg.sv | 62 ++++++
 rtl/dzmcu_dma.sv | 64 ++++++
 rtl/dzmcu.sv | 166 ++++++++++++++++
 tb/tb_dzmcu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dzmcu_pkg.sv
// Shared definitions for the memory control unit: region codes, fixed register
// addresses, DMA state encoding and the address decoder.
package dzmcu_pkg;

  typedef enum logic [2:0] {
    RegBoot,
    RegCart,
    RegVram,
    RegWram,
    RegOam,
    RegNone,
    RegIo,
    RegInt
  } region_e;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } dma_state_e;

  localparam logic [15:0] AddrDma  = 16'hFF46;
  localparam logic [15:0] AddrBoot = 16'hFF50;
  localparam logic [15:0] AddrHram = 16'hFF80;
  localparam logic [15:0] AddrIe   = 16'hFFFF;

  localparam int unsigned DmaLenDefault = 160;

  // FF46/FF50 sit inside the IO window but are served internally.
  function automatic region_e decode(input logic [15:0] addr, input logic boot);
    if (addr < 16'h0100) return boot ? RegBoot : RegCart;
    if (addr < 16'h8000) return RegCart;
    if (addr < 16'hA000) return RegVram;
    if (addr < 16'hC000) return RegCart;
    if (addr < 16'hFE00) return RegWram;
    if (addr < 16'hFEA0) return RegOam;
    if (addr < 16'hFF00) return RegNone;
    if (addr == AddrDma || addr == AddrBoot) return RegInt;
    if (addr < AddrHram) return RegIo;
    return RegInt;
  endfunction

  function automatic logic [7:0] rd_mux(input region_e    sel,
                                        input logic [7:0] boot_d,
                                        input logic [7:0] cart_d,
                                        input logic [7:0] vram_d,
                                        input logic [7:0] wram_d,
                                        input logic [7:0] oam_d,
                                        input logic [7:0] io_d,
                                        input logic [7:0] intl_d);
    unique case (sel)
      RegBoot: return boot_d;
      RegCart: return cart_d;
      RegVram: return vram_d;
      RegWram: return wram_d;
      RegOam:  return oam_d;
      RegIo:   return io_d;
      RegInt:  return intl_d;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dzmcu_dma.sv
// OAM DMA engine: walks a source page one byte per cycle and writes OAM one
// cycle behind, using the data returned for the previous source read.
module dzmcu_dma import dzmcu_pkg::*; #(
  parameter int unsigned DMA_LEN = DmaLenDefault
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        start_i,
  input  logic [7:0]  page_i,
  input  logic [7:0]  rd_data_i,
  output logic [15:0] src_addr_o,
  output logic [7:0]  page_o,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_we_o,
  output logic        busy_o
);

  localparam logic [7:0] LastIdx = 8'(DMA_LEN);

  dma_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] page_q, page_d;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      page_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      // Count runs one past the last read so the final OAM write can drain.
      StRun: begin
        if (cnt_q == LastIdx) state_d = StIdle;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
    if (start_i) begin
      state_d = StRun;
      cnt_d   = '0;
      page_d  = page_i;
    end
  end

  assign busy_o     = (state_q == StRun);
  assign src_addr_o = {page_q, cnt_q};
  assign page_o     = page_q;
  assign oam_addr_o = cnt_q - 8'd1;
  assign oam_data_o = rd_data_i;
  assign oam_we_o   = busy_o && (cnt_q != 8'd0) && !iReset;

endmodule

// File: rtl/dzmcu.sv
// Memory control unit: address decode, 1-cycle read mux, boot overlay latch,
// HRAM, IE register and OAM DMA bus arbitration.
module dzmcu import dzmcu_pkg::*; #(
  parameter int unsigned DMA_LEN       = DmaLenDefault,
  parameter bit          BOOT_AT_RESET = 1'b1,
  parameter int unsigned HRAM_SIZE     = 127
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  input  logic        iCpuReadRequest,
  output logic [7:0]  oCpuData,
  output logic [7:0]  oBootAddr,
  input  logic [7:0]  iBootData,
  output logic [15:0] oCartAddr,
  input  logic [7:0]  iCartData,
  output logic [7:0]  oCartData,
  output logic        oCartWe,
  output logic [12:0] oVramAddr,
  input  logic [7:0]  iVramData,
  output logic [7:0]  oVramData,
  output logic        oVramWe,
  output logic [12:0] oWramAddr,
  input  logic [7:0]  iWramData,
  output logic [7:0]  oWramData,
  output logic        oWramWe,
  output logic [7:0]  oOamAddr,
  input  logic [7:0]  iOamData,
  output logic [7:0]  oOamData,
  output logic        oOamWe,
  output logic [6:0]  oIoAddr,
  input  logic [7:0]  iIoData,
  output logic [7:0]  oIoData,
  output logic        oIoWe,
  output logic [7:0]  oIE,
  output logic        oDmaBusy
);

  logic       boot_q, boot_d;
  logic [7:0] ie_q, ie_d;
  logic [7:0] hram_q [HRAM_SIZE];

  region_e    cpu_sel_q, cpu_sel_d, dma_sel_q, dma_sel_d;
  logic [7:0] cpu_int_q, cpu_int_d, dma_int_q, dma_int_d;

  logic        dma_busy, dma_oam_we, dma_start;
  logic [15:0] dma_src, act_addr;
  logic [7:0]  dma_page, dma_oam_addr, dma_oam_data, dma_rd_data;

  region_e cpu_region;
  logic    cpu_hi, cpu_open, cpu_wr, cpu_oam_we;

  // Internally served bytes; anything else in this path reads as open bus.
  function automatic logic [7:0] int_rd(input logic [15:0] a);
    if (a == AddrDma)  return dma_page;
    if (a == AddrBoot) return {7'h7F, ~boot_q};
    if (a == AddrIe)   return ie_q;
    if (a >= AddrHram) return hram_q[a[6:0]];
    return 8'hFF;
  endfunction

  assign cpu_region = decode(iCpuAddr, boot_q);
  assign cpu_hi     = (iCpuAddr >= AddrHram);
  // While DMA runs the CPU only reaches HRAM/IE and the DMA register itself.
  assign cpu_open   = !dma_busy || cpu_hi || (iCpuAddr == AddrDma);
  assign cpu_wr     = iCpuWe && cpu_open && !iReset;
  assign dma_start  = cpu_wr && (iCpuAddr == AddrDma);

  dzmcu_dma #(
    .DMA_LEN(DMA_LEN)
  ) u_dma (
    .iClock    (iClock),
    .iReset    (iReset),
    .start_i   (dma_start),
    .page_i    (iCpuData),
    .rd_data_i (dma_rd_data),
    .src_addr_o(dma_src),
    .page_o    (dma_page),
    .oam_addr_o(dma_oam_addr),
    .oam_data_o(dma_oam_data),
    .oam_we_o  (dma_oam_we),
    .busy_o    (dma_busy)
  );

  always_comb begin
    cpu_sel_d = cpu_sel_q;
    cpu_int_d = cpu_int_q;
    if (iCpuReadRequest) begin
      cpu_sel_d = cpu_open ? cpu_region : RegNone;
      cpu_int_d = int_rd(iCpuAddr);
    end
    dma_sel_d = decode(dma_src, boot_q);
    dma_int_d = int_rd(dma_src);
  end

  always_comb begin
    boot_d = boot_q;
    ie_d   = ie_q;
    if (cpu_wr && iCpuAddr == AddrBoot && iCpuData != 8'h00) boot_d = 1'b0;
    if (cpu_wr && iCpuAddr == AddrIe) ie_d = iCpuData;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      boot_q    <= BOOT_AT_RESET;
      ie_q      <= '0;
      cpu_sel_q <= RegInt;
      cpu_int_q <= '0;
      dma_sel_q <= RegNone;
      dma_int_q <= 8'hFF;
    end else begin
      boot_q    <= boot_d;
      ie_q      <= ie_d;
      cpu_sel_q <= cpu_sel_d;
      cpu_int_q <= cpu_int_d;
      dma_sel_q <= dma_sel_d;
      dma_int_q <= dma_int_d;
    end
  end

  always_ff @(posedge iClock) begin
    if (cpu_wr && cpu_hi && iCpuAddr != AddrIe) hram_q[iCpuAddr[6:0]] <= iCpuData;
  end

  always_comb begin
    oCartWe    = 1'b0;
    oVramWe    = 1'b0;
    oWramWe    = 1'b0;
    oIoWe      = 1'b0;
    cpu_oam_we = 1'b0;
    if (cpu_wr) begin
      unique case (cpu_region)
        RegBoot, RegCart: oCartWe    = 1'b1;
        RegVram:          oVramWe    = 1'b1;
        RegWram:          oWramWe    = 1'b1;
        RegOam:           cpu_oam_we = 1'b1;
        RegIo:            oIoWe      = 1'b1;
        default:          oCartWe    = 1'b0;
      endcase
    end
  end

  assign act_addr  = dma_busy ? dma_src : iCpuAddr;
  assign oBootAddr = act_addr[7:0];
  assign oCartAddr = act_addr;
  assign oVramAddr = act_addr[12:0];
  assign oWramAddr = act_addr[12:0];
  assign oIoAddr   = act_addr[6:0];
  assign oOamAddr  = dma_busy ? dma_oam_addr : iCpuAddr[7:0];
  assign oOamData  = dma_busy ? dma_oam_data : iCpuData;
  assign oOamWe    = dma_oam_we | cpu_oam_we;
  assign oCartData = iCpuData;
  assign oVramData = iCpuData;
  assign oWramData = iCpuData;
  assign oIoData   = iCpuData;

  assign dma_rd_data = rd_mux(dma_sel_q, iBootData, iCartData, iVramData, iWramData, iOamData,
                              iIoData, dma_int_q);
  assign oCpuData    = rd_mux(cpu_sel_q, iBootData, iCartData, iVramData, iWramData, iOamData,
                              iIoData, cpu_int_q);
  assign oIE         = ie_q;
  assign oDmaBusy    = dma_busy;

endmodule

// File: tb/tb_dzmcu.sv
// Scoreboard bench for dzmcu: stimulus queues expected reads/writes, a monitor
// compares them as the DUT presents read data or write strobes.
module tb_dzmcu;

  localparam int TNone = 0, TCart = 1, TVram = 2, TWram = 3, TOam = 4, TIo = 5;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe, iCpuReadRequest;
  logic [7:0]  oCpuData, oBootAddr, iBootData;
  logic [15:0] oCartAddr;
  logic [7:0]  iCartData, oCartData;
  logic        oCartWe;
  logic [12:0] oVramAddr, oWramAddr;
  logic [7:0]  iVramData, oVramData, iWramData, oWramData;
  logic        oVramWe, oWramWe;
  logic [7:0]  oOamAddr, iOamData, oOamData;
  logic        oOamWe;
  logic [6:0]  oIoAddr;
  logic [7:0]  iIoData, oIoData, oIE;
  logic        oIoWe, oDmaBusy;

  dzmcu #(
    .DMA_LEN      (160),
    .BOOT_AT_RESET(1'b1),
    .HRAM_SIZE    (127)
  ) dut (
    .iClock(iClock), .iReset(iReset),
    .iCpuAddr(iCpuAddr), .iCpuData(iCpuData), .iCpuWe(iCpuWe),
    .iCpuReadRequest(iCpuReadRequest), .oCpuData(oCpuData),
    .oBootAddr(oBootAddr), .iBootData(iBootData),
    .oCartAddr(oCartAddr), .iCartData(iCartData), .oCartData(oCartData), .oCartWe(oCartWe),
    .oVramAddr(oVramAddr), .iVramData(iVramData), .oVramData(oVramData), .oVramWe(oVramWe),
    .oWramAddr(oWramAddr), .iWramData(iWramData), .oWramData(oWramData), .oWramWe(oWramWe),
    .oOamAddr(oOamAddr), .iOamData(iOamData), .oOamData(oOamData), .oOamWe(oOamWe),
    .oIoAddr(oIoAddr), .iIoData(iIoData), .oIoData(oIoData), .oIoWe(oIoWe),
    .oIE(oIE), .oDmaBusy(oDmaBusy)
  );

  always #5 iClock = ~iClock;

  // Memory models: 1-cycle synchronous reads with address-derived contents.
  logic [7:0] oam_m [256];
  always @(posedge iClock) begin
    iBootData <= oBootAddr ^ 8'hB0;
    iCartData <= oCartAddr[7:0] ^ oCartAddr[15:8] ^ 8'h3C;
    iVramData <= oVramAddr[7:0] ^ 8'h66;
    iWramData <= oWramAddr[12] ? (oWramAddr[7:0] ^ 8'h5A) : oWramAddr[7:0];
    iOamData  <= oam_m[oOamAddr];
    iIoData   <= {1'b1, oIoAddr};
    if (oOamWe) oam_m[oOamAddr] <= oOamData;
  end

  typedef struct {
    int          tgt;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  string      rd_nm[$];

  int checks = 0, failures = 0;
  int dma_pulses = 0, busy_cyc = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic       pend = 1'b0;
    wr_t        e;
    int         nwe, tgt;
    logic [15:0] a;
    logic [7:0] d;
    forever begin
      @(negedge iClock);
      if (pend) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else check(rd_nm.pop_front(), int'(oCpuData), int'(rd_q.pop_front()));
      end
      pend = iCpuReadRequest && !iReset;
      if (oDmaBusy) busy_cyc++;
      nwe = $countones({oCartWe, oVramWe, oWramWe, oIoWe, oOamWe && !oDmaBusy});
      if (oOamWe && oDmaBusy) begin
        dma_pulses++;
        if (nwe != 0) check("we_during_dma", nwe, 0);
      end else if (nwe > 1) begin
        check("we_onehot", nwe, 1);
      end else if (nwe == 1) begin
        tgt = TNone; a = '0; d = '0;
        if (oCartWe) begin tgt = TCart; a = oCartAddr;        d = oCartData; end
        if (oVramWe) begin tgt = TVram; a = {3'b0, oVramAddr}; d = oVramData; end
        if (oWramWe) begin tgt = TWram; a = {3'b0, oWramAddr}; d = oWramData; end
        if (oOamWe)  begin tgt = TOam;  a = {8'b0, oOamAddr};  d = oOamData;  end
        if (oIoWe)   begin tgt = TIo;   a = {9'b0, oIoAddr};   d = oIoData;   end
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected got tgt=%0d addr=%h data=%h expected none", tgt, a, d);
        end else begin
          e = wr_q.pop_front();
          if (tgt != e.tgt || a !== e.addr || d !== e.data) begin
            failures++;
            $display("FAIL wr_match got tgt=%0d addr=%h data=%h expected tgt=%0d addr=%h data=%h",
                     tgt, a, d, e.tgt, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge iClock);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    iCpuAddr = a; iCpuWe = 1'b0; iCpuReadRequest = 1'b1;
    rd_q.push_back(exp);
    rd_nm.push_back(name);
    cyc();
    iCpuReadRequest = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] v, input int tgt,
                    input logic [15:0] ea);
    wr_t e;
    iCpuAddr = a; iCpuData = v; iCpuWe = 1'b1; iCpuReadRequest = 1'b0;
    if (tgt != TNone) begin
      e.tgt = tgt; e.addr = ea; e.data = v;
      wr_q.push_back(e);
    end
    cyc();
    iCpuWe = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (oDmaBusy && n < 500) begin
      cyc();
      n++;
    end
    check(name, int'(oDmaBusy), 0);
    cyc();
  endtask

  task automatic check_oam(input string name, input logic [7:0] xr);
    int bad = 0;
    for (int i = 0; i < 160; i++) begin
      logic [7:0] ev;
      ev = 8'(i) ^ xr;
      if (oam_m[i] !== ev) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int p0, b0;
    iReset = 1'b1; iCpuAddr = '0; iCpuData = '0; iCpuWe = 1'b0; iCpuReadRequest = 1'b0;
    fork
      monitor();
    join_none
    repeat (2) cyc();
    iReset = 1'b0;
    check("rst_cpudata", int'(oCpuData), 0);
    check("rst_ie", int'(oIE), 0);
    check("rst_busy", int'(oDmaBusy), 0);
    check("rst_we", int'({oCartWe, oVramWe, oWramWe, oOamWe, oIoWe}), 0);

    rd(16'h0000, 8'hB0, "boot_rd");
    wr(16'hFF50, 8'h01, TNone, '0);
    rd(16'h0000, 8'h3C, "cart_after_ff50");
    wr(16'hFF50, 8'h00, TNone, '0);
    rd(16'h0000, 8'h3C, "boot_sticky");
    rd(16'hFF50, 8'hFF, "ff50_rd_off");
    wr(16'hE123, 8'h5A, TWram, 16'h0123);
    rd(16'hE005, 8'h05, "echo_rd");
    rd(16'hC0A7, 8'hA7, "wram_rd");
    rd(16'hFEA5, 8'hFF, "unusable_rd");
    wr(16'hFEA5, 8'h77, TNone, '0);
    wr(16'h9800, 8'h11, TVram, 16'h1800);
    rd(16'h8123, 8'h45, "vram_rd");
    wr(16'h2000, 8'h01, TCart, 16'h2000);
    rd(16'h4321, 8'h5E, "cart_rd");
    wr(16'hFF01, 8'h22, TIo, 16'h0001);
    rd(16'hFF05, 8'h85, "io_rd");
    wr(16'hFFFF, 8'h1F, TNone, '0);
    check("ie_out", int'(oIE), 'h1F);
    rd(16'hFFFF, 8'h1F, "ie_rd");
    wr(16'hFF80, 8'h12, TNone, '0);
    wr(16'hFFFE, 8'h34, TNone, '0);
    rd(16'hFF80, 8'h12, "hram_lo_rd");
    rd(16'hFFFE, 8'h34, "hram_hi_rd");
    rd(16'hFF46, 8'h00, "ff46_rst_rd");

    // Plain DMA from WRAM page C0, with CPU traffic while it runs.
    p0 = dma_pulses; b0 = busy_cyc;
    wr(16'hFF46, 8'hC0, TNone, '0);
    rd(16'h8000, 8'hFF, "dma_blocked_rd");
    wr(16'h8000, 8'h99, TNone, '0);
    wr(16'hFF90, 8'hAB, TNone, '0);
    rd(16'hFF90, 8'hAB, "dma_hram_rd");
    rd(16'hFF46, 8'hC0, "dma_page_rd");
    wait_idle("dma_done");
    check("dma_pulses", dma_pulses - p0, 160);
    check("dma_busy_cycles", busy_cyc - b0, 161);
    check_oam("dma_oam_c0", 8'h00);

    // Restart at i=50 onto page D0.
    p0 = dma_pulses; b0 = busy_cyc;
    wr(16'hFF46, 8'hC0, TNone, '0);
    repeat (50) cyc();
    wr(16'hFF46, 8'hD0, TNone, '0);
    wait_idle("restart_done");
    check("restart_pulses", dma_pulses - p0, 210);
    check("restart_busy_cycles", busy_cyc - b0, 212);
    check_oam("restart_oam_d0", 8'h5A);

    // Reset while the DMA is at i=80.
    p0 = dma_pulses;
    wr(16'hFF46, 8'hC0, TNone, '0);
    repeat (80) cyc();
    iReset = 1'b1;
    cyc();
    iReset = 1'b0;
    check("rst_dma_oamwe", int'(oOamWe), 0);
    check("rst_dma_busy", int'(oDmaBusy), 0);
    check("rst_dma_pulses", dma_pulses - p0, 79);
    rd(16'h0000, 8'hB0, "boot_after_rst");
    rd(16'hFF50, 8'hFE, "ff50_after_rst");

    repeat (3) cyc();
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
